// File: rtl/power_mode_sequencer_pkg.sv
// Shared power-mode encodings, sequencer FSM states and wake-source bit positions.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package power_mode_pkg;

  // power_mode encodings, also decoded by clock_gate_controller
  localparam logic [1:0] MODE_DEEPSLEEP = 2'b00;
  localparam logic [1:0] MODE_STANDBY   = 2'b01;
  localparam logic [1:0] MODE_ACTIVE    = 2'b10;

  typedef enum logic [2:0] {
    ST_ACTIVE      = 3'd0,
    ST_STANDBY     = 3'd1,
    ST_ENTER_SLEEP = 3'd2,
    ST_DEEPSLEEP   = 3'd3,
    ST_EXIT_SLEEP  = 3'd4
  } pm_state_e;

  // Bit positions inside wakeup_source / wake_cause ({can,timer,uart_rx,gpio})
  localparam int WAKE_SRC_GPIO    = 0;
  localparam int WAKE_SRC_UART_RX = 1;
  localparam int WAKE_SRC_TIMER   = 2;
  localparam int WAKE_SRC_CAN     = 3;

  // Power mode presented to the clock gating while in a given state.
  function automatic logic [1:0] mode_of(input pm_state_e s);
    logic [1:0] m;
    case (s)
      ST_ACTIVE:    m = MODE_ACTIVE;
      ST_DEEPSLEEP: m = MODE_DEEPSLEEP;
      default:      m = MODE_STANDBY;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/power_mode_sequencer_idle_counter.sv
// Saturating idle-cycle counter with synchronous clear and threshold-hit compare.
// Latency: hit is combinational from the registered count; count updates each clk edge.
// Backpressure: none; clr has priority over counting.
// Ports: clk/rst (sync, active-high), clr (zero the count), thresh (0 disables hit),
//        hit (high in the cycle that completes exactly thresh idle cycles).
module pm_idle_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] thresh,
  output logic         hit
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   cnt_inc;

  // One bit wider so a saturated count never aliases onto a small threshold.
  assign cnt_inc = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};
  assign hit     = (thresh != '0) && (cnt_inc == {1'b0, thresh});

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (!(&cnt_q)) begin
      cnt_d = cnt_inc[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/power_mode_sequencer.sv
// Always-on power-mode sequencer: ACTIVE/STANDBY/DEEPSLEEP with drain and settle phases.
// Latency: all outputs registered; a qualifying input moves state/outputs on the next edge.
// Backpressure: none; wakeup_request is acknowledged one-for-one, every cycle it is high.
// Ports: clk_master/rst (sync, active-high); cim_active, dvfs_busy, uart_active form busy;
//        sleep_req (level), standby_thresh/sleep_thresh (0 disables); wakeup_request/source;
//        power_mode, pm_state, mode_change, wakeup_ack, wake_cause, sleep_count.
module power_mode_sequencer
  import power_mode_pkg::*;
#(
  parameter int IDLE_W       = 16,
  parameter int ENTRY_CYCLES = 8,
  parameter int EXIT_CYCLES  = 4
) (
  input  logic              clk_master,
  input  logic              rst,
  input  logic              cim_active,
  input  logic              dvfs_busy,
  input  logic              uart_active,
  input  logic              sleep_req,
  input  logic [IDLE_W-1:0] standby_thresh,
  input  logic [IDLE_W-1:0] sleep_thresh,
  input  logic              wakeup_request,
  input  logic [3:0]        wakeup_source,
  output logic [1:0]        power_mode,
  output logic [2:0]        pm_state,
  output logic              mode_change,
  output logic              wakeup_ack,
  output logic [3:0]        wake_cause,
  output logic [15:0]       sleep_count
);

  localparam int PH_MAX = (ENTRY_CYCLES > EXIT_CYCLES) ? ENTRY_CYCLES : EXIT_CYCLES;
  localparam int PH_W   = (PH_MAX > 2) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] ENTRY_LOAD = PH_W'(ENTRY_CYCLES - 1);
  localparam logic [PH_W-1:0] EXIT_LOAD  = PH_W'(EXIT_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_ONE     = PH_W'(1);

  pm_state_e         state_q, state_d;
  logic [1:0]        power_mode_q, power_mode_d;
  logic              mode_change_q, mode_change_d;
  logic              wakeup_ack_q, wakeup_ack_d;
  logic [3:0]        wake_cause_q, wake_cause_d;
  logic [15:0]       sleep_count_q, sleep_count_d;
  logic [PH_W-1:0]   phase_q, phase_d;

  logic              busy;
  logic              state_chg;
  logic              idle_clr;
  logic              idle_hit;
  logic [IDLE_W-1:0] idle_thresh;

  assign busy = cim_active | dvfs_busy | uart_active;

  // Only ACTIVE and STANDBY demote on idleness; elsewhere the compare is disabled.
  always_comb begin
    idle_thresh = '0;
    case (state_q)
      ST_ACTIVE:  idle_thresh = standby_thresh;
      ST_STANDBY: idle_thresh = sleep_thresh;
      default:    idle_thresh = '0;
    endcase
  end

  pm_idle_counter #(
    .W (IDLE_W)
  ) u_idle_counter (
    .clk    (clk_master),
    .rst    (rst),
    .clr    (idle_clr),
    .thresh (idle_thresh),
    .hit    (idle_hit)
  );

  always_comb begin
    state_d       = state_q;
    wake_cause_d  = wake_cause_q;
    sleep_count_d = sleep_count_q;
    case (state_q)
      ST_ACTIVE: begin
        // A wake request while already ACTIVE only earns an ack and holds off demotion.
        if (wakeup_request || busy) begin
          state_d = ST_ACTIVE;
        end else if (sleep_req) begin
          state_d = ST_ENTER_SLEEP;
        end else if (idle_hit) begin
          state_d = ST_STANDBY;
        end
      end
      ST_STANDBY: begin
        if (wakeup_request || busy) begin
          state_d = ST_ACTIVE;
        end else if (sleep_req || idle_hit) begin
          state_d = ST_ENTER_SLEEP;
        end
      end
      ST_ENTER_SLEEP: begin
        // Abort beats the final drain cycle, so no sleep is counted on a late wake.
        if (wakeup_request || busy) begin
          state_d = ST_ACTIVE;
        end else if (phase_q == '0) begin
          state_d       = ST_DEEPSLEEP;
          sleep_count_d = sleep_count_q + 16'd1;
        end
      end
      ST_DEEPSLEEP: begin
        if (wakeup_request) begin
          state_d = ST_EXIT_SLEEP;
          wake_cause_d[WAKE_SRC_GPIO]    = wakeup_source[WAKE_SRC_GPIO];
          wake_cause_d[WAKE_SRC_UART_RX] = wakeup_source[WAKE_SRC_UART_RX];
          wake_cause_d[WAKE_SRC_TIMER]   = wakeup_source[WAKE_SRC_TIMER];
          wake_cause_d[WAKE_SRC_CAN]     = wakeup_source[WAKE_SRC_CAN];
        end
      end
      ST_EXIT_SLEEP: begin
        if (phase_q == '0) begin
          state_d = ST_ACTIVE;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  assign state_chg = (state_d != state_q);
  assign idle_clr  = busy | state_chg;

  always_comb begin
    phase_d       = phase_q;
    power_mode_d  = mode_of(state_d);
    mode_change_d = (power_mode_d != power_mode_q);
    wakeup_ack_d  = wakeup_request;
    if (state_chg && (state_d == ST_ENTER_SLEEP)) begin
      phase_d = ENTRY_LOAD;
    end else if (state_chg && (state_d == ST_EXIT_SLEEP)) begin
      phase_d = EXIT_LOAD;
    end else if (phase_q != '0) begin
      phase_d = phase_q - PH_ONE;
    end
  end

  always_ff @(posedge clk_master) begin
    if (rst) begin
      state_q       <= ST_ACTIVE;
      power_mode_q  <= MODE_ACTIVE;
      mode_change_q <= 1'b0;
      wakeup_ack_q  <= 1'b0;
      wake_cause_q  <= '0;
      sleep_count_q <= '0;
      phase_q       <= '0;
    end else begin
      state_q       <= state_d;
      power_mode_q  <= power_mode_d;
      mode_change_q <= mode_change_d;
      wakeup_ack_q  <= wakeup_ack_d;
      wake_cause_q  <= wake_cause_d;
      sleep_count_q <= sleep_count_d;
      phase_q       <= phase_d;
    end
  end

  assign power_mode  = power_mode_q;
  assign pm_state    = state_q;
  assign mode_change = mode_change_q;
  assign wakeup_ack  = wakeup_ack_q;
  assign wake_cause  = wake_cause_q;
  assign sleep_count = sleep_count_q;

endmodule
